// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared encodings for the RV32I hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

   localparam logic [1:0] FWD_REGFILE    = 2'b00;
   localparam logic [1:0] FWD_WB         = 2'b01;
   localparam logic [1:0] FWD_MEM        = 2'b10;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

   // Bubble counter width; covers LOAD_STALL_CYCLES up to 15.
   localparam int         CNT_W          = 4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage fields in, Execute operand selects and F/D/E pipeline-register strobes out.
interface hazard_fwd_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int PERF_CNT_W = 32
);

   logic                  valid_d;
   logic [REG_ADDR_W-1:0] rs1_d;
   logic [REG_ADDR_W-1:0] rs2_d;
   logic [REG_ADDR_W-1:0] rd_d;
   logic                  regwrite_d;
   logic [1:0]            resultsrc_d;
   logic                  pcsrc_e;

   logic [1:0]            forward_a_e;
   logic [1:0]            forward_b_e;
   logic                  stall_f;
   logic                  stall_d;
   logic                  flush_d;
   logic                  flush_e;
   logic [PERF_CNT_W-1:0] stall_cnt;

   modport master (
      output valid_d, rs1_d, rs2_d, rd_d, regwrite_d, resultsrc_d, pcsrc_e,
      input  forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
   );

   modport slave (
      input  valid_d, rs1_d, rs2_d, rd_d, regwrite_d, resultsrc_d, pcsrc_e,
      output forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e, stall_cnt
   );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// One Execute operand mux select: MEM result beats WB result beats register file; x0 never forwards.
// Purely combinational, no state and no handshake.
module hazard_fwd_ctrl_fwd_sel
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic                  regwrite_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  regwrite_w,
   output logic [1:0]            sel
);

   logic hit_m;
   logic hit_w;

   assign hit_m = regwrite_m && (rd_m != '0) && (rd_m == src);
   assign hit_w = regwrite_w && (rd_w != '0) && (rd_w == src);

   always_comb begin
      sel = FWD_REGFILE;
      if (hit_m) begin
         sel = FWD_MEM;
      end else if (hit_w) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller: Execute forwarding selects plus F/D/E stall and flush strobes from shadow E/M/W state.
// Zero latency; load-use inserts LOAD_STALL_CYCLES bubbles, a taken branch overrides any stall.
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W        = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int PERF_CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   hazard_fwd_ctrl_if.slave hz
);

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  regwrite;
      logic                  load;
   } ex_stage_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
   } dst_stage_t;

   ex_stage_t             ex_q;
   ex_stage_t             ex_d;
   dst_stage_t            mem_q;
   dst_stage_t            wb_q;

   state_t                state_q;
   state_t                state_n;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_n;
   logic [PERF_CNT_W-1:0] stall_cnt_q;

   logic                  lwhaz;
   logic                  stall;
   logic                  flush_ex;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;

   // Shadow pipeline: only Decode fields are supplied, older stages are tracked here.
   always_comb begin
      ex_d = '0;
      if (!flush_ex) begin
         ex_d.rd       = hz.rd_d;
         ex_d.rs1      = hz.rs1_d;
         ex_d.rs2      = hz.rs2_d;
         ex_d.regwrite = hz.regwrite_d & hz.valid_d;
         ex_d.load     = (hz.resultsrc_d == RESULTSRC_LOAD) & hz.valid_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= dst_stage_t'{ex_q.rd, ex_q.regwrite};
         wb_q  <= mem_q;
      end
   end

   hazard_fwd_ctrl_fwd_sel #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_sel_a (
      .src        (ex_q.rs1),
      .rd_m       (mem_q.rd),
      .regwrite_m (mem_q.regwrite),
      .rd_w       (wb_q.rd),
      .regwrite_w (wb_q.regwrite),
      .sel        (fwd_a)
   );

   hazard_fwd_ctrl_fwd_sel #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_sel_b (
      .src        (ex_q.rs2),
      .rd_m       (mem_q.rd),
      .regwrite_m (mem_q.regwrite),
      .rd_w       (wb_q.rd),
      .regwrite_w (wb_q.regwrite),
      .sel        (fwd_b)
   );

   assign lwhaz = ex_q.load && (ex_q.rd != '0) && hz.valid_d &&
                  ((ex_q.rd == hz.rs1_d) || (ex_q.rd == hz.rs2_d));

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      stall   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (lwhaz) begin
               stall = 1'b1;
               cnt_n = CNT_W'(LOAD_STALL_CYCLES - 1);
               if (cnt_n != '0) begin
                  state_n = ST_STALL;
               end
            end
         end
         ST_STALL: begin
            stall = 1'b1;
            cnt_n = cnt_q - CNT_W'(1);
            if (cnt_n == '0) begin
               state_n = ST_RUN;
            end
         end
      endcase
      // A taken branch squashes the stalled instruction, so its bubbles are moot.
      if (hz.pcsrc_e) begin
         state_n = ST_RUN;
         cnt_n   = '0;
         stall   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
      end
   end

   assign flush_ex = stall | hz.pcsrc_e;

   // pcsrc_e is a live input, so the flush strobes are masked to stay quiet while reset is held.
   assign hz.forward_a_e = fwd_a;
   assign hz.forward_b_e = fwd_b;
   assign hz.stall_f     = stall;
   assign hz.stall_d     = stall;
   assign hz.flush_d     = hz.pcsrc_e & reset_n;
   assign hz.flush_e     = flush_ex & reset_n;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two instances (1 and 3 load bubbles) share one stimulus stream against a pipeline-history model.
module tb_hazard_fwd_ctrl;

   logic  clk     = 1'b0;
   logic  reset_n = 1'b0;
   int    checks  = 0;
   int    errors  = 0;
   string phase   = "init";

   always #5 clk = ~clk;

   hazard_fwd_ctrl_if #(.REG_ADDR_W(5), .PERF_CNT_W(32)) bus1 ();
   hazard_fwd_ctrl_if #(.REG_ADDR_W(5), .PERF_CNT_W(32)) bus3 ();

   hazard_fwd_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .PERF_CNT_W(32)) dut1 (
      .clk(clk), .reset_n(reset_n), .hz(bus1));
   hazard_fwd_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .PERF_CNT_W(32)) dut3 (
      .clk(clk), .reset_n(reset_n), .hz(bus3));

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       wr;
      logic       ld;
   } ins_t;

   // Model: instruction history per instance, index 0 = Execute, 1 = Memory, 2 = Writeback.
   ins_t    pipe [2][3];
   int      bub    [2];
   longint  scnt   [2];
   int      nstall [2];

   logic [1:0]  o_fa [2];
   logic [1:0]  o_fb [2];
   logic        o_sf [2];
   logic        o_sd [2];
   logic        o_fd [2];
   logic        o_fe [2];
   logic [31:0] o_sc [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic sample();
      o_fa[0] = bus1.forward_a_e; o_fa[1] = bus3.forward_a_e;
      o_fb[0] = bus1.forward_b_e; o_fb[1] = bus3.forward_b_e;
      o_sf[0] = bus1.stall_f;     o_sf[1] = bus3.stall_f;
      o_sd[0] = bus1.stall_d;     o_sd[1] = bus3.stall_d;
      o_fd[0] = bus1.flush_d;     o_fd[1] = bus3.flush_d;
      o_fe[0] = bus1.flush_e;     o_fe[1] = bus3.flush_e;
      o_sc[0] = bus1.stall_cnt;   o_sc[1] = bus3.stall_cnt;
   endtask

   task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rdd, input logic wr, input logic [1:0] rs, input logic br);
      bus1.valid_d = v;   bus1.rs1_d = r1; bus1.rs2_d = r2; bus1.rd_d = rdd;
      bus1.regwrite_d = wr; bus1.resultsrc_d = rs; bus1.pcsrc_e = br;
      bus3.valid_d = v;   bus3.rs1_d = r1; bus3.rs2_d = r2; bus3.rd_d = rdd;
      bus3.regwrite_d = wr; bus3.resultsrc_d = rs; bus3.pcsrc_e = br;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 3; a++) pipe[k][a] = '0;
         bub[k]  = 0;
         scnt[k] = 0;
      end
   endtask

   function automatic logic [1:0] exp_fwd(input int k, input logic [4:0] src);
      for (int a = 1; a <= 2; a++) begin
         if (pipe[k][a].wr && pipe[k][a].rd != 5'd0 && pipe[k][a].rd == src)
            return (a == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   task automatic chk_zero(input string tag);
      sample();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_n%0d_fa", tag, nstall[k]), 32'(o_fa[k]), 32'd0);
         chk($sformatf("%s_n%0d_fb", tag, nstall[k]), 32'(o_fb[k]), 32'd0);
         chk($sformatf("%s_n%0d_sf", tag, nstall[k]), 32'(o_sf[k]), 32'd0);
         chk($sformatf("%s_n%0d_sd", tag, nstall[k]), 32'(o_sd[k]), 32'd0);
         chk($sformatf("%s_n%0d_fd", tag, nstall[k]), 32'(o_fd[k]), 32'd0);
         chk($sformatf("%s_n%0d_fe", tag, nstall[k]), 32'(o_fe[k]), 32'd0);
         chk($sformatf("%s_n%0d_cnt", tag, nstall[k]), o_sc[k], 32'd0);
      end
   endtask

   // One cycle: entered just after a rising edge, checked at the falling edge, model advanced at the next rising edge.
   task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd, input logic wr, input logic [1:0] rs, input logic br);
      logic st [2];
      drive(v, r1, r2, rdd, wr, rs, br);
      @(negedge clk);
      sample();
      for (int k = 0; k < 2; k++) begin
         logic hzd;
         hzd = pipe[k][0].ld && pipe[k][0].rd != 5'd0 && v &&
               (pipe[k][0].rd == r1 || pipe[k][0].rd == r2);
         st[k] = !br && (bub[k] > 0 || hzd);
         chk($sformatf("n%0d_fwd_a", nstall[k]), 32'(o_fa[k]), 32'(exp_fwd(k, pipe[k][0].rs1)));
         chk($sformatf("n%0d_fwd_b", nstall[k]), 32'(o_fb[k]), 32'(exp_fwd(k, pipe[k][0].rs2)));
         chk($sformatf("n%0d_stall_f", nstall[k]), 32'(o_sf[k]), 32'(st[k]));
         chk($sformatf("n%0d_stall_d", nstall[k]), 32'(o_sd[k]), 32'(st[k]));
         chk($sformatf("n%0d_flush_d", nstall[k]), 32'(o_fd[k]), 32'(br));
         chk($sformatf("n%0d_flush_e", nstall[k]), 32'(o_fe[k]), 32'(st[k] || br));
         chk($sformatf("n%0d_stall_cnt", nstall[k]), o_sc[k], 32'(scnt[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (br) begin
            bub[k] = 0;
         end else if (st[k]) begin
            if (bub[k] == 0) bub[k] = nstall[k];
            bub[k]--;
         end
         if (st[k] && scnt[k] != 64'hFFFF_FFFF) scnt[k]++;
         pipe[k][2] = pipe[k][1];
         pipe[k][1] = pipe[k][0];
         pipe[k][0] = (st[k] || br) ? '0 : ins_t'{rdd, r1, r2, wr & v, (rs == 2'b01) & v};
      end
      #1;
   endtask

   initial begin
      logic [31:0] base1;
      logic [31:0] base3;
      nstall[0] = 1;
      nstall[1] = 3;
      model_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
      #2;
      phase = "reset";
      chk_zero("rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      phase = "mem_fwd";
      step(1, 0, 0, 5, 1, 2'b00, 0);
      step(1, 5, 0, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      chk("mem_fa", 32'(o_fa[0]), 32'(2'b10));
      chk("mem_fb", 32'(o_fb[0]), 32'(2'b00));

      phase = "prio";
      step(1, 0, 0, 7, 1, 2'b00, 0);
      step(1, 0, 0, 7, 1, 2'b00, 0);
      step(1, 7, 7, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      chk("prio_fa", 32'(o_fa[1]), 32'(2'b10));
      chk("prio_fb", 32'(o_fb[1]), 32'(2'b10));

      phase = "wb_fwd";
      step(1, 0, 0, 7, 1, 2'b00, 0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      step(1, 7, 0, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      chk("wb_fa", 32'(o_fa[0]), 32'(2'b01));

      phase = "x0";
      step(1, 0, 0, 0, 1, 2'b01, 0);
      step(1, 0, 0, 0, 1, 2'b00, 0);
      chk("x0_nostall", 32'(o_sd[1]), 32'd0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      chk("x0_fa", 32'(o_fa[0]), 32'd0);
      chk("x0_fb", 32'(o_fb[0]), 32'd0);

      phase = "load_use";
      step(1, 0, 0, 6, 1, 2'b01, 0);
      base1 = o_sc[0];
      base3 = o_sc[1];
      step(1, 0, 6, 9, 1, 2'b00, 0);
      chk("lu_a_n1", 32'(o_sd[0]), 32'd1);
      chk("lu_a_n3", 32'(o_fe[1]), 32'd1);
      step(1, 0, 6, 9, 1, 2'b00, 0);
      chk("lu_b_n1", 32'(o_sd[0]), 32'd0);
      chk("lu_b_n3", 32'(o_sf[1]), 32'd1);
      step(1, 0, 6, 9, 1, 2'b00, 0);
      chk("lu_c_fb_n1", 32'(o_fb[0]), 32'(2'b01));
      chk("lu_c_n3", 32'(o_sd[1]), 32'd1);
      step(1, 0, 6, 9, 1, 2'b00, 0);
      chk("lu_d_n3", 32'(o_sd[1]), 32'd0);
      step(1, 0, 0, 0, 0, 2'b00, 0);
      chk("lu_fb_n3", 32'(o_fb[1]), 32'(2'b00));
      chk("lu_cnt_n1", o_sc[0] - base1, 32'd1);
      chk("lu_cnt_n3", o_sc[1] - base3, 32'd3);

      phase = "branch_stall";
      step(1, 0, 0, 6, 1, 2'b01, 0);
      step(1, 6, 0, 0, 0, 2'b00, 0);
      step(1, 6, 0, 0, 0, 2'b00, 1);
      chk("br_fd", 32'(o_fd[1]), 32'd1);
      chk("br_fe", 32'(o_fe[1]), 32'd1);
      chk("br_sd", 32'(o_sd[1]), 32'd0);
      chk("br_sf", 32'(o_sf[1]), 32'd0);
      step(1, 6, 0, 0, 0, 2'b00, 0);
      chk("br_after", 32'(o_sd[1]), 32'd0);

      phase = "async_rst";
      step(1, 0, 0, 6, 1, 2'b01, 0);
      step(1, 6, 6, 0, 0, 2'b00, 0);
      drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 2'b00, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_zero("mid");
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("held");
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 20; i++) begin
         step(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 2'b00, 0);
         chk("post_rst_nostall", 32'(o_sd[0] | o_sd[1]), 32'd0);
      end

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) != 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 3) ? 2'b01 : 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It generates the select codes for the three-input forwarding muxes on ALU operands A and B in the Execute stage. It also generates the stall and flush strobes for the Fetch, Decode and Execute pipeline registers. It keeps its own shadow copies of destination and source register info for E/M/W, so the datapath only supplies Decode-stage fields plus the taken-branch flag.

Parameters:
REG_ADDR_W, 5, register-file address width.
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15; >1 models slow data memory).
PERF_CNT_W, 32, width of the stall performance counter.

Ports:
clk  input  1  core clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
valid_d  input  1  Decode holds a real instruction.
rs1_d  input  REG_ADDR_W  Decode source 1.
rs2_d  input  REG_ADDR_W  Decode source 2.
rd_d  input  REG_ADDR_W  Decode destination.
regwrite_d  input  1  Decode instruction writes rd.
resultsrc_d  input  2  Decode result source; 2'b01 = load.
pcsrc_e  input  1  taken branch/jump resolved in Execute.
forward_a_e  output  2  operand-A mux select: 00 regfile, 01 WB result, 10 MEM ALU result.
forward_b_e  output  2  operand-B mux select, same encoding.
stall_f  output  1  hold PC.
stall_d  output  1  hold IF/ID register.
flush_d  output  1  clear IF/ID register.
flush_e  output  1  clear ID/EX register.
stall_cnt  output  PERF_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async, reset_n=0) clears all of the following immediately:
  - E/M/W shadow registers: rd=0, regwrite=0, load=0, rs1E=rs2E=0.
  - FSM set to RUN; stall counter set to 0; stall_cnt set to 0.
  - All outputs read 0 / 2'b00 while reset is held.
- Shadow pipeline, updated every clk edge:
  - W<-M and M<-E unconditionally.
  - E<-D fields (regwrite and load gated by valid_d) unless flush_e=1, in which case E is loaded with a bubble (all zero).
- Forwarding is combinational from the shadow state:
  - forward_a_e=10 if regwriteM && rdM!=0 && rdM==rs1E.
  - Otherwise 01 if regwriteW && rdW!=0 && rdW==rs1E.
  - Otherwise 00.
  - forward_b_e is identical with rs2E.
  - MEM has priority over WB. Code 11 is never driven.
- Load-use detect: lwhaz = loadE && rdE!=0 && valid_d && (rdE==rs1_d || rdE==rs2_d).
- FSM states: RUN, STALL.
  - RUN: if lwhaz && !pcsrc_e, assert stall_f=stall_d=flush_e=1 this cycle. Load cnt with LOAD_STALL_CYCLES-1. If cnt!=0, go to STALL; else stay in RUN.
  - STALL: assert stall_f=stall_d=flush_e=1 and decrement cnt. Return to RUN when cnt reaches 0 and the current cycle is the last bubble.
  - Net result: exactly LOAD_STALL_CYCLES consecutive stall cycles per hazard.
- Branch: pcsrc_e=1 gives flush_d=1 and flush_e=1 in the same cycle.
  - Branch wins over any stall: stall_f=stall_d=0, FSM forced to RUN, cnt cleared.
- stall_cnt increments by 1 on every cycle with stall_d=1 and saturates at all-ones.
- All outputs are combinational from registered state plus current D inputs. There is no added latency and no combinational path from forward_* to stall_*.
- Reset deasserted mid-stall: the FSM restarts in RUN, with no residual bubbles.

Decomposition:
- Shared package/header holds:
  - FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RESULTSRC_LOAD=2'b01.
  - FSM encodings ST_RUN / ST_STALL.
- One natural sub-module, fwd_sel: compares one source register against the M/W destinations and produces a 2-bit select. It is instantiated twice (A and B).

Test Plan:
1. Forward from MEM: issue add x5 (regwrite_d=1, rd_d=5), then next cycle rs1_d=5 -> two edges later forward_a_e=10 and forward_b_e=00.
2. Forward from WB and priority:
   - Issue x7 writes at t and t+1, followed by a reader of x7 -> forward=10 (MEM wins).
   - With a single writer at distance 2 -> forward=01.
3. x0 suppression: writer with rd_d=0, reader rs1_d=rs2_d=0 -> forward_a_e=forward_b_e=00 and no stall.
4. Load-use, LOAD_STALL_CYCLES=1 then 3: lw x6 followed by rs2_d=6 -> stall_f=stall_d=flush_e=1 for exactly 1 (resp. 3) cycles. stall_cnt increases by 1 (resp. 3). Once the load reaches W, the reader gets forward_b_e=01 (N=1) or 00 (N=3).
5. Branch during stall (N=3): pcsrc_e=1 in the 2nd bubble cycle -> flush_d=flush_e=1, stall_f=stall_d=0 that cycle, FSM in RUN on the next edge, no further stalls.
6. Async reset mid-stall: drop reset_n between edges -> all outputs 0 and stall_cnt=0 immediately. After release, a non-dependent instruction stream produces no stalls.
